regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next LemonPC core generation.
- Generalises the single-write / dual-read register file: NR read ports, NW write ports, an optional write-to-read bypass, and a per-register busy scoreboard for issue/writeback tracking.
- Sits between decode (reads, allocation) and writeback (writes).
- Register 0 is hardwired to zero.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register data width.
- NR, 2, number of read ports (1..4).
- NW, 1, number of write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array contents only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NR*ADDR_WIDTH  read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NR*DATA_WIDTH  read data, combinational.
- rd_busy  output  NR  busy bit of each read index, combinational.
- wr_en  input  NW  write enables.
- wr_addr  input  NW*ADDR_WIDTH  write indices.
- wr_data  input  NW*DATA_WIDTH  write data.
- alloc_en  input  1  mark alloc_addr busy (a producer has been issued).
- alloc_addr  input  ADDR_WIDTH  register being allocated.
- busy  output  2**ADDR_WIDTH  full scoreboard vector, registered.

Behaviour:
- Reset (asynchronous, effective immediately on rst assertion):
  - all registers cleared to 0; busy cleared to 0.
  - consequently rd_data reads 0 and rd_busy reads 0 on every port.
- Reset asserted mid-operation: pending writes and allocations in that cycle are discarded; no partial update.
- Write:
  - on posedge, for each port w with wr_en[w]=1 and wr_addr[w]!=0, rf[wr_addr[w]] <= wr_data[w].
  - writes to index 0 are dropped.
- Write collision: two write ports enabled to the same index → the highest-numbered port wins, for both the array update and the bypass.
- Read:
  - rd_data[k] = 0 if rd_addr[k]==0.
  - else, with BYPASS=1 and a same-cycle enabled write to that index, the winning write data.
  - else rf[rd_addr[k]].
  - latency 0 (combinational); new write is visible through the array on the next cycle.
- Scoreboard update on posedge, per index i≠0:
  - set if alloc_en and alloc_addr==i.
  - else cleared if any enabled write hits i.
  - else held.
  - Allocation and writeback to the same index in the same cycle → busy stays 1, because the new producer supersedes the old one.
  - alloc_addr==0 is ignored; busy[0] is constant 0.
- rd_busy[k]:
  - = busy[rd_addr[k]], except with BYPASS=1 it reads 0 when a same-cycle write clears that index.
  - Same-cycle allocation is not forwarded to rd_busy.
- Widths: addresses unsigned; no sign or zero-extension inside the block; data is stored verbatim.

Optional Feature:
- Macro: REGFILE_TRACE_EN.
- Defined:
  - simulation-only shadow copy of the array.
  - each posedge with any write, $display one line per register whose value changed: "x<idx> changed, from 0x<old>(<old signed>) to 0x<new>(<new signed>)".
  - one line per busy-bit transition: "x<idx> busy <0|1>".
  - writes that leave the value unchanged print nothing.
- Undefined:
  - no shadow state and no $display.
  - synthesised logic is identical in both cases.

Decomposition:
- Package regfile_pkg:
  - REG_ZERO index constant.
  - default ADDR_WIDTH and DATA_WIDTH constants.
  - function for packed-port slicing (port k, width W).
- Sub-module regfile_scoreboard(ADDR_WIDTH, NW):
  - busy vector with set/clear priority and x0 masking.
  - exposes busy and a next-cycle clear mask used for the rd_busy bypass.
- The array and read muxing stay in regfile_mp.

Test Plan:
- Reset: write x5=0x1234, then assert rst between edges → rd_data for x5 reads 0 immediately; busy==0.
- Bypass, BYPASS=1: wr_en[0]=1, wr_addr=3, wr_data=0xDEAD, rd_addr[0]=3 in the same cycle → rd_data[0]=0xDEAD before the edge; after the edge with wr_en=0 → still 0xDEAD. With BYPASS=0 → old value before the edge.
- x0 and collision, NW=2:
  - write x0=0xFF → reads 0.
  - port0 x7=0x11 and port1 x7=0x22 in the same cycle → x7=0x22.
- Scoreboard:
  - alloc x9 → busy[9]=1 next cycle.
  - write x9 → busy[9]=0 next cycle.
  - alloc x9 plus write x9 in the same cycle → busy[9] stays 1, x9 holds the written data.
- rd_busy bypass: busy[4]=1 and a write to x4 in the same cycle with rd_addr[1]=4 → rd_busy[1]=0 (BYPASS=1), 1 (BYPASS=0).
- Trace (REGFILE_TRACE_EN): write x2 0→-1 → prints "x2 changed, from 0x0(0) to 0xffffffffffffffff(-1)"; rewrite x2=-1 → no print.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;

  // Index of the hardwired-zero register.
  localparam int REG_ZERO = 0;

  // Bit offset of port k inside a packed multi-port bus of per-port width w.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: allocation sets a bit, writeback clears it,
// allocation wins over a same-cycle writeback, and x0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NW         = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic [NW-1:0]                wr_en,
  input  logic [NW*ADDR_WIDTH-1:0]     wr_addr,
  output logic [(2**ADDR_WIDTH)-1:0]   busy,
  output logic [(2**ADDR_WIDTH)-1:0]   clr_mask
);

  logic [(2**ADDR_WIDTH)-1:0] set_mask;
  logic [(2**ADDR_WIDTH)-1:0] hit_mask;

  // Decode this cycle's allocation and writeback hits; a hit only clears a
  // bit when no new producer is allocated to the same register.
  always_comb begin
    set_mask = '0;
    hit_mask = '0;
    if (alloc_en) begin
      set_mask[alloc_addr] = 1'b1;
    end
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w]) begin
        hit_mask[wr_addr[port_lsb(w, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end
    set_mask[REG_ZERO] = 1'b0;
    hit_mask[REG_ZERO] = 1'b0;
    clr_mask = hit_mask & ~set_mask;
  end

  // Busy state: set has priority, then clear, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= set_mask | (busy & ~clr_mask);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// busy scoreboard. x0 reads as zero and ignores writes.
// Optional simulation trace: define REGFILE_TRACE_EN to print value and
// busy-bit changes; synthesised logic is the same either way.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR         = 2,
  parameter int NW         = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR*ADDR_WIDTH-1:0]     rd_addr,
  output logic [NR*DATA_WIDTH-1:0]     rd_data,
  output logic [NR-1:0]                rd_busy,
  input  logic [NW-1:0]                wr_en,
  input  logic [NW*ADDR_WIDTH-1:0]     wr_addr,
  input  logic [NW*DATA_WIDTH-1:0]     wr_data,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic [(2**ADDR_WIDTH)-1:0]   busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      clr_mask;

  logic [ADDR_WIDTH-1:0] wa [NW];
  logic [DATA_WIDTH-1:0] wd [NW];
  logic [ADDR_WIDTH-1:0] ra [NR];
  logic [DATA_WIDTH-1:0] rd_word [NR];
  logic                  rd_bsy  [NR];

  for (genvar w = 0; w < NW; w++) begin : g_wr_unpack
    assign wa[w] = wr_addr[port_lsb(w, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wd[w] = wr_data[port_lsb(w, DATA_WIDTH) +: DATA_WIDTH];
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd_pack
    assign ra[k] = rd_addr[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
    assign rd_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = rd_word[k];
    assign rd_busy[k] = rd_bsy[k];
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NW         (NW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .clr_mask   (clr_mask)
  );

  // Register array; ports are applied in ascending order so the
  // highest-numbered port wins a same-index collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && (wa[w] != ZERO_IDX)) begin
          rf[wa[w]] <= wd[w];
        end
      end
    end
  end

  // Read muxing: array contents, optionally overridden by the winning
  // same-cycle write; x0 and an asserted reset force zero.
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      rd_word[k] = rf[ra[k]];
      rd_bsy[k]  = busy[ra[k]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (wr_en[w] && (wa[w] == ra[k])) begin
            rd_word[k] = wd[w];
          end
        end
        rd_bsy[k] = busy[ra[k]] & ~clr_mask[ra[k]];
      end
      if (rst || (ra[k] == ZERO_IDX)) begin
        rd_word[k] = '0;
        rd_bsy[k]  = 1'b0;
      end
    end
  end

`ifdef REGFILE_TRACE_EN
  logic [DATA_WIDTH-1:0] shadow_rf [DEPTH];
  logic [DEPTH-1:0]      shadow_busy;

  // Trace register value changes caused by each edge's writes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_rf[i] = '0;
      end
    end else if (|wr_en) begin
      for (int i = 1; i < DEPTH; i++) begin
        logic [DATA_WIDTH-1:0] nv;
        nv = shadow_rf[i];
        for (int w = 0; w < NW; w++) begin
          if (wr_en[w] && (wa[w] == ADDR_WIDTH'(i))) begin
            nv = wd[w];
          end
        end
        if (nv != shadow_rf[i]) begin
          $display("x%0d changed, from 0x%0h(%0d) to 0x%0h(%0d)", i,
                   shadow_rf[i], $signed(shadow_rf[i]), nv, $signed(nv));
        end
        shadow_rf[i] = nv;
      end
    end
  end

  // Trace every busy-bit transition.
  always @(busy) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] != shadow_busy[i]) begin
        $display("x%0d busy %0d", i, busy[i]);
      end
    end
    shadow_busy = busy;
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on/off) share one stimulus;
// directed table, reset sequences, then randomized traffic against a model.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic [NR-1:0]    rd_busy_a, rd_busy_b;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [31:0]      busy_a, busy_b;

  always #5 clk = ~clk;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_a));

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_b));

  int errors = 0;
  int checks = 0;

  // Reference state: plain register contents and a set of busy registers.
  logic [DW-1:0] m_rf [32];
  bit   [31:0]   m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] rda(input int k);
    logic [NR*AW-1:0] v;
    v = rd_addr;
    return v[k*AW +: AW];
  endfunction

  function automatic bit wr_hits(input logic [4:0] a, output logic [DW-1:0] d);
    bit hit;
    hit = 0;
    d = '0;
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
        hit = 1;
        d = wr_data[w*DW +: DW];
      end
    end
    return hit;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [4:0] a, input bit byp);
    logic [DW-1:0] d;
    if (rst || a == 0) return '0;
    if (byp && wr_hits(a, d)) return d;
    return m_rf[a];
  endfunction

  function automatic logic exp_rb(input logic [4:0] a, input bit byp);
    logic [DW-1:0] d;
    if (rst || a == 0) return 1'b0;
    if (byp && wr_hits(a, d) && !(alloc_en && alloc_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_busy = '0;
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge();
    logic [DW-1:0] d;
    bit [31:0] nb;
    if (rst) begin
      model_reset();
      return;
    end
    nb = m_busy;
    for (int i = 1; i < 32; i++) begin
      if (alloc_en && alloc_addr == i) nb[i] = 1'b1;
      else if (wr_hits(5'(i), d)) nb[i] = 1'b0;
    end
    m_busy = nb;
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] != 0)
        m_rf[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s rd_data_byp[%0d]", tag, k), rd_data_a[k*DW +: DW], exp_rd(rda(k), 1));
      chk($sformatf("%s rd_data_nobyp[%0d]", tag, k), rd_data_b[k*DW +: DW], exp_rd(rda(k), 0));
      chk($sformatf("%s rd_busy_byp[%0d]", tag, k), rd_busy_a[k], exp_rb(rda(k), 1));
      chk($sformatf("%s rd_busy_nobyp[%0d]", tag, k), rd_busy_b[k], exp_rb(rda(k), 0));
    end
    chk($sformatf("%s busy_byp", tag), busy_a, m_busy);
    chk($sformatf("%s busy_nobyp", tag), busy_b, m_busy);
  endtask

  task automatic drive(input logic r, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [63:0] wd0,
                       input logic [4:0] wa1, input logic [63:0] wd1,
                       input logic ae, input logic [4:0] aa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    rst        = r;
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    alloc_en   = ae;
    alloc_addr = aa;
    rd_addr    = {ra1, ra0};
    if (r) model_reset();
    #1;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] ea_rd0;
    logic [63:0] ea_rd1;
    logic        ea_rb1;
    logic [63:0] eb_rd0;
    logic        eb_rb1;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Each row: inputs held for one cycle, outputs checked before the edge.
    tbl[0]  = '{2'b01, 5'd3, 64'hDEAD, 5'd0, 64'h0,  1'b0, 5'd0, 5'd3, 5'd0, 64'hDEAD, 64'h0,    1'b0, 64'h0,    1'b0};
    tbl[1]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b0, 5'd0, 5'd3, 5'd3, 64'hDEAD, 64'hDEAD, 1'b0, 64'hDEAD, 1'b0};
    tbl[2]  = '{2'b01, 5'd0, 64'hFF,   5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 5'd3, 64'h0,    64'hDEAD, 1'b0, 64'h0,    1'b0};
    tbl[3]  = '{2'b11, 5'd7, 64'h11,   5'd7, 64'h22, 1'b0, 5'd0, 5'd7, 5'd7, 64'h22,   64'h22,   1'b0, 64'h0,    1'b0};
    tbl[4]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b0, 5'd0, 5'd7, 5'd0, 64'h22,   64'h0,    1'b0, 64'h22,   1'b0};
    tbl[5]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b1, 5'd9, 5'd9, 5'd9, 64'h0,    64'h0,    1'b0, 64'h0,    1'b0};
    tbl[6]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 64'h0,    64'h0,    1'b1, 64'h0,    1'b1};
    tbl[7]  = '{2'b01, 5'd9, 64'h99,   5'd0, 64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 64'h99,   64'h99,   1'b0, 64'h0,    1'b1};
    tbl[8]  = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 64'h99,   64'h99,   1'b0, 64'h99,   1'b0};
    tbl[9]  = '{2'b01, 5'd9, 64'hAA,   5'd0, 64'h0,  1'b1, 5'd9, 5'd9, 5'd9, 64'hAA,   64'hAA,   1'b0, 64'h99,   1'b0};
    tbl[10] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 64'hAA,   64'hAA,   1'b1, 64'hAA,   1'b1};
    tbl[11] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b1, 5'd4, 5'd4, 5'd4, 64'h0,    64'h0,    1'b0, 64'h0,    1'b0};
    tbl[12] = '{2'b10, 5'd0, 64'h0,    5'd4, 64'h44, 1'b0, 5'd0, 5'd4, 5'd4, 64'h44,   64'h44,   1'b0, 64'h0,    1'b1};
    tbl[13] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 64'h0,    1'b0};

    // Power-on reset
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = {5'd1, 5'd2};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rd_data_byp", rd_data_a, '0);
    chk("reset rd_busy_byp", {62'b0, rd_busy_a}, '0);
    chk("reset busy", busy_a, '0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
            tbl[i].ae, tbl[i].aa, tbl[i].ra0, tbl[i].ra1);
      chk($sformatf("row%0d byp rd0", i), rd_data_a[0 +: DW], tbl[i].ea_rd0);
      chk($sformatf("row%0d byp rd1", i), rd_data_a[DW +: DW], tbl[i].ea_rd1);
      chk($sformatf("row%0d byp rb1", i), rd_busy_a[1], tbl[i].ea_rb1);
      chk($sformatf("row%0d nobyp rd0", i), rd_data_b[0 +: DW], tbl[i].eb_rd0);
      chk($sformatf("row%0d nobyp rb1", i), rd_busy_b[1], tbl[i].eb_rb1);
      check_model($sformatf("row%0d", i));
      @(posedge clk);
      model_edge();
    end
    drive(1'b0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd9, 5'd4);
    chk("busy[9] after alloc+write", busy_a[9], 1'b1);
    chk("busy[4] after write", busy_a[4], 1'b0);
    chk("busy[0] after alloc x0", busy_a[0], 1'b0);
    @(posedge clk);
    model_edge();

    // Asynchronous reset between edges, with a pending write and allocation
    drive(1'b0, 2'b01, 5'd5, 64'h1234, 5'd0, 64'h0, 1'b1, 5'd5, 5'd5, 5'd9);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {64'h0, 64'h5555};
    alloc_en = 1'b1; alloc_addr = 5'd6; rd_addr = {5'd6, 5'd5};
    #1;
    chk("pre-reset x5", rd_data_b[0 +: DW], 64'h1234);
    chk("pre-reset busy[5]", busy_a[5], 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid-reset x5 immediate", rd_data_a[0 +: DW], 64'h0);
    chk("mid-reset x6 bypass", rd_data_a[DW +: DW], 64'h0);
    chk("mid-reset busy", busy_a, 32'h0);
    chk("mid-reset rd_busy", {62'b0, rd_busy_a}, '0);
    @(posedge clk);
    model_edge();
    drive(1'b0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    chk("post-reset x6 dropped", rd_data_b[DW +: DW], 64'h0);
    chk("post-reset busy", busy_b, 32'h0);
    @(posedge clk);
    model_edge();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic [4:0] a0, a1, aa, r0, r1;
      r  = ($urandom_range(0, 39) == 0);
      a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      aa = 5'($urandom_range(0, 7));
      r0 = 5'($urandom_range(0, 9));
      r1 = ($urandom_range(0, 1) != 0) ? a1 : 5'($urandom_range(0, 31));
      drive(r, 2'($urandom_range(0, 3)), a0, {$urandom, $urandom}, a1, {$urandom, $urandom},
            1'($urandom_range(0, 1)), aa, r0, r1);
      check_model($sformatf("rand%0d", n));
      @(posedge clk);
      model_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
